lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit downstream of the instruction decoder. Consumes the decoder's is_load/is_store funct3 codes
//  (3'b111 = no op), the ALU-computed effective address and rs2 data. Runs one memory transaction per op over a
//  valid/ready request + response-valid data-memory port. Returns sign/zero-extended load data for register writeback.
// PARAMETERS
//  TIMEOUT   255  cycles allowed in WAIT for mem_resp_valid before abort with err (8-bit counter)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  start           in   1   issue pulse from core; sampled only in IDLE
//  is_load         in   3   000 LB,001 LH,010 LW,100 LBU,101 LHU,111 none
//  is_store        in   3   000 SB,001 SH,010 SW,111 none
//  addr            in   32  effective byte address (rs1+imm)
//  wdata           in   32  rs2 store data, LSB-aligned
//  busy            out  1   high in any state except IDLE
//  done            out  1   1-cycle pulse: op finished (success, misalign or timeout)
//  rdata           out  32  extended load result; held until next done
//  err             out  1   valid with done: misaligned or timeout
//  mem_req_valid   out  1   request valid
//  mem_req_ready   in   1   memory accepts request
//  mem_req_wen     out  1   1=write
//  mem_req_addr    out  32  {addr[31:2],2'b00}
//  mem_req_wdata   out  32  store data replicated into lanes
//  mem_req_wmask   out  4   byte enables (0000 for reads)
//  mem_resp_valid  in   1   read data / write ack valid
//  mem_resp_rdata  in   32  read word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, rdata 32'h0, timeout counter 0. Reset mid-transaction aborts silently (no done).
//  FSM IDLE->REQ->WAIT->DONE->IDLE:
//   IDLE: on start, latch op, addr, wdata. Load!=111 wins if both valid. Both 111 -> DONE, no access, err=0.
//         Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) -> DONE with err=1, no access.
//   REQ:  mem_req_valid=1, fields stable until valid&&ready; then WAIT, counter cleared.
//   WAIT: on mem_resp_valid -> DONE; loads capture extended rdata same edge. Counter==TIMEOUT -> DONE, err=1.
//   DONE: done=1 for one cycle -> IDLE. start during busy/DONE is ignored (not queued).
//  Lane select by addr[1:0]: byte lane k=addr[1:0], half lane addr[1]. LB/LH sign-extend bit 7/15, LBU/LHU zero-extend.
//  Store wmask: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111. wdata: byte x4 / half x2 / word.
//  Store completes on write ack (mem_resp_valid); rdata unchanged by stores and by error ops.
//  Latency, ready=1 and resp one cycle after accept: start @T, req @T+1, resp @T+2, done @T+3. Misalign/none: done @T+1.
//  mem_resp_valid outside WAIT is ignored.
// STRUCTURE
//  Shared package: LD_*/ST_* funct3 codes, OP_NONE=3'b111, FSM state encoding.
//  One sub-module: lsu_data_align (comb.) — store lane replication/wmask and load lane extract/extend.
// TESTING
//  LB addr=0x1003, resp 0x80FF_0000 -> mem_req_addr 0x1000, wmask 0000, rdata 0xFFFF_FF80, done @T+3, err=0.
//  SH addr=0x2002 wdata=0x0000_ABCD -> wmask 1100, wdata 0xABCD_ABCD, wen=1; done after ack.
//  LW addr=0x3001 -> no mem_req_valid, done @T+1, err=1, rdata unchanged.
//  mem_req_ready low 5 cycles -> req fields stable throughout; done 1 cycle after resp.
//  No mem_resp_valid after accept -> done+err exactly TIMEOUT+1 cycles into WAIT; next start serviced.
//  Assert rst while in WAIT -> all outputs 0 asynchronously, no done; LBU 0x..F0 then yields 0x0000_00F0.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 op codes, FSM encoding,
// timeout default and the alignment check used at issue time.
package lsu_mem_ctrl_pkg;

   localparam logic [2:0] LD_LB   = 3'b000;
   localparam logic [2:0] LD_LH   = 3'b001;
   localparam logic [2:0] LD_LW   = 3'b010;
   localparam logic [2:0] LD_LBU  = 3'b100;
   localparam logic [2:0] LD_LHU  = 3'b101;
   localparam logic [2:0] ST_SB   = 3'b000;
   localparam logic [2:0] ST_SH   = 3'b001;
   localparam logic [2:0] ST_SW   = 3'b010;
   localparam logic [2:0] OP_NONE = 3'b111;

   localparam logic [7:0] TIMEOUT_DEF = 8'd255;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_t;

   // Size is carried in funct3[1:0] for both loads and stores (01 half, 10 word)
   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
      return ((op[1:0] == 2'b01) && lo[0]) || ((op[1:0] == 2'b10) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_data_align.sv
// Combinational lane steering: store replication + byte mask, load lane
// extraction + sign/zero extension.
import lsu_mem_ctrl_pkg::*;

module lsu_data_align (
   input  logic [2:0]  ld_op,
   input  logic [2:0]  st_op,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;

   // Pick the addressed byte/half out of the returned word and extend it
   always_comb begin
      shifted = rword >> {lane, 3'b000};
      b       = shifted[7:0];
      h       = lane[1] ? rword[31:16] : rword[15:0];
      case (ld_op)
         LD_LB:   ld_data = {{24{b[7]}}, b};
         LD_LH:   ld_data = {{16{h[15]}}, h};
         LD_LBU:  ld_data = {24'h0, b};
         LD_LHU:  ld_data = {16'h0, h};
         default: ld_data = rword;
      endcase
   end

   // Replicate store data into every lane; the mask selects which lanes land
   always_comb begin
      wmask     = 4'b0000;
      wdata_rep = 32'h0;
      case (st_op)
         ST_SB: begin
            wmask     = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
         end
         ST_SH: begin
            wmask     = 4'b0011 << {lane[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         ST_SW: begin
            wmask     = 4'b1111;
            wdata_rep = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one memory transaction per issued op over a valid/ready
// request port, with response-valid completion and a bounded wait.
import lsu_mem_ctrl_pkg::*;

module lsu_mem_ctrl #(
   parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  is_load,
   input  logic [2:0]  is_store,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata
);

   lsu_state_t  state;
   logic [2:0]  ld_q, st_q, sel_op;
   logic [31:0] addr_q, wdata_q, ld_data;
   logic [7:0]  cnt;

   // Loads take priority when the decoder flags both
   always_comb begin
      sel_op = (is_load != OP_NONE) ? is_load : is_store;
   end

   // Request fields come straight from the latched op, so they hold through REQ
   assign mem_req_addr = {addr_q[31:2], 2'b00};
   assign mem_req_wen  = (st_q != OP_NONE);

   lsu_data_align u_align (
      .ld_op     (ld_q),
      .st_op     (st_q),
      .lane      (addr_q[1:0]),
      .wdata     (wdata_q),
      .rword     (mem_resp_rdata),
      .wmask     (mem_req_wmask),
      .wdata_rep (mem_req_wdata),
      .ld_data   (ld_data)
   );

   // Transaction FSM with registered status/handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         ld_q          <= OP_NONE;
         st_q          <= OP_NONE;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         cnt           <= 8'h0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         mem_req_valid <= 1'b0;
         rdata         <= 32'h0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  busy    <= 1'b1;
                  if (is_load != OP_NONE) begin
                     ld_q <= is_load;
                     st_q <= OP_NONE;
                  end else begin
                     ld_q <= OP_NONE;
                     st_q <= is_store;
                  end
                  if (sel_op == OP_NONE) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b0;
                  end else if (misaligned(sel_op, addr[1:0])) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state         <= S_REQ;
                     mem_req_valid <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  cnt           <= 8'h0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  if (ld_q != OP_NONE) rdata <= ld_data;
                  state <= S_DONE;
                  done  <= 1'b1;
                  err   <= 1'b0;
               end else if (cnt == TIMEOUT) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               err   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: hand-computed vectors, immediate assertions.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  is_load, is_store;
   logic [31:0] addr, wdata;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   int n_asrt = 0;
   int n_fail = 0;
   int k;

   always #5 clk = ~clk;

   lsu_mem_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .is_load        (is_load),
      .is_store       (is_store),
      .addr           (addr),
      .wdata          (wdata),
      .busy           (busy),
      .done           (done),
      .rdata          (rdata),
      .err            (err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_wen    (mem_req_wen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] ld, input logic [2:0] st,
                        input logic [31:0] a, input logic [31:0] wd);
      start    = 1'b1;
      is_load  = ld;
      is_store = st;
      addr     = a;
      wdata    = wd;
   endtask

   task automatic idle_in();
      start    = 1'b0;
      is_load  = 3'b111;
      is_store = 3'b111;
   endtask

   initial begin
      rst = 1'b1; idle_in(); addr = 32'h0; wdata = 32'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
      step(); step();
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_valid", {31'h0, mem_req_valid}, 32'h0);
      chk("rst_wen", {31'h0, mem_req_wen}, 32'h0);
      chk("rst_addr", mem_req_addr, 32'h0);
      chk("rst_wdata", mem_req_wdata, 32'h0);
      chk("rst_wmask", {28'h0, mem_req_wmask}, 32'h0);
      rst = 1'b0;
      mem_req_ready = 1'b1;

      // LB from lane 3, sign-extended
      step(); issue(3'b000, 3'b111, 32'h0000_1003, 32'h0);          // T
      step(); idle_in();                                              // T+1
      chk("lb_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("lb_addr", mem_req_addr, 32'h0000_1000);
      chk("lb_wmask", {28'h0, mem_req_wmask}, 32'h0);
      chk("lb_wen", {31'h0, mem_req_wen}, 32'h0);
      chk("lb_busy", {31'h0, busy}, 32'h1);
      chk("lb_done_early", {31'h0, done}, 32'h0);
      step();                                                         // T+2
      chk("lb_valid_drop", {31'h0, mem_req_valid}, 32'h0);
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80FF_0000;
      step(); mem_resp_valid = 1'b0;                                  // T+3
      chk("lb_done", {31'h0, done}, 32'h1);
      chk("lb_err", {31'h0, err}, 32'h0);
      chk("lb_rdata", rdata, 32'hFFFF_FF80);
      step();
      chk("lb_done_pulse", {31'h0, done}, 32'h0);
      chk("lb_idle", {31'h0, busy}, 32'h0);

      // SH to upper half
      issue(3'b111, 3'b001, 32'h0000_2002, 32'h0000_ABCD);
      step(); idle_in();
      chk("sh_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("sh_wmask", {28'h0, mem_req_wmask}, 32'hC);
      chk("sh_wdata", mem_req_wdata, 32'hABCD_ABCD);
      chk("sh_wen", {31'h0, mem_req_wen}, 32'h1);
      chk("sh_addr", mem_req_addr, 32'h0000_2000);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
      step(); mem_resp_valid = 1'b0;
      chk("sh_done", {31'h0, done}, 32'h1);
      chk("sh_err", {31'h0, err}, 32'h0);
      chk("sh_rdata_kept", rdata, 32'hFFFF_FF80);
      step();

      // Misaligned LW: no request, done next cycle with err
      issue(3'b010, 3'b111, 32'h0000_3001, 32'h0);
      step(); idle_in();
      chk("lw_mis_done", {31'h0, done}, 32'h1);
      chk("lw_mis_err", {31'h0, err}, 32'h1);
      chk("lw_mis_valid", {31'h0, mem_req_valid}, 32'h0);
      chk("lw_mis_rdata", rdata, 32'hFFFF_FF80);
      step();
      chk("lw_mis_pulse", {31'h0, done}, 32'h0);

      // No op: done next cycle, no error
      issue(3'b111, 3'b111, 32'h0000_0000, 32'h0);
      step(); idle_in();
      chk("none_done", {31'h0, done}, 32'h1);
      chk("none_err", {31'h0, err}, 32'h0);
      chk("none_valid", {31'h0, mem_req_valid}, 32'h0);
      step();

      // Ready held low 5 cycles, SB lane 1; stray start while busy is dropped
      mem_req_ready = 1'b0;
      issue(3'b111, 3'b000, 32'h0000_4001, 32'h0000_005A);
      step();
      issue(3'b111, 3'b010, 32'h0000_9000, 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         chk("rdy_valid", {31'h0, mem_req_valid}, 32'h1);
         chk("rdy_addr", mem_req_addr, 32'h0000_4000);
         chk("rdy_wmask", {28'h0, mem_req_wmask}, 32'h2);
         chk("rdy_wdata", mem_req_wdata, 32'h5A5A_5A5A);
      end
      mem_req_ready = 1'b1;
      step();
      chk("rdy_wait", {31'h0, mem_req_valid}, 32'h0);
      idle_in();
      mem_resp_valid = 1'b1;
      step(); mem_resp_valid = 1'b0;
      chk("rdy_done", {31'h0, done}, 32'h1);
      step();
      chk("rdy_not_queued", {31'h0, busy}, 32'h0);

      // Load wins over store when both flagged
      issue(3'b010, 3'b010, 32'h0000_8000, 32'hDEAD_BEEF);
      step(); idle_in();
      chk("both_wen", {31'h0, mem_req_wen}, 32'h0);
      chk("both_wmask", {28'h0, mem_req_wmask}, 32'h0);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
      step(); mem_resp_valid = 1'b0;
      chk("both_rdata", rdata, 32'hCAFE_F00D);
      step();

      // Timeout: no response after accept
      issue(3'b010, 3'b111, 32'h0000_5000, 32'h0);
      step(); idle_in();
      step();                                    // first WAIT cycle
      k = 0;
      while (!done && k < 300) begin
         step();
         k++;
      end
      chk("to_cycles", k, 32'd256);
      chk("to_done", {31'h0, done}, 32'h1);
      chk("to_err", {31'h0, err}, 32'h1);
      chk("to_rdata", rdata, 32'hCAFE_F00D);
      step();

      // Next op serviced after timeout: LH from upper half, negative
      issue(3'b001, 3'b111, 32'h0000_6002, 32'h0);
      step(); idle_in();
      chk("lh_valid", {31'h0, mem_req_valid}, 32'h1);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h8234_0000;
      step(); mem_resp_valid = 1'b0;
      chk("lh_done", {31'h0, done}, 32'h1);
      chk("lh_rdata", rdata, 32'hFFFF_8234);
      step();

      // Reset while in WAIT: async clear, no done afterwards
      issue(3'b000, 3'b111, 32'h0000_7000, 32'h0);
      step(); idle_in();
      step();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'h0, busy}, 32'h0);
      chk("arst_rdata", rdata, 32'h0);
      chk("arst_done", {31'h0, done}, 32'h0);
      chk("arst_valid", {31'h0, mem_req_valid}, 32'h0);
      step(); rst = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;  // outside WAIT, ignored
      step(); mem_resp_valid = 1'b0;
      chk("arst_no_done", {31'h0, done}, 32'h0);
      chk("arst_ignore_resp", rdata, 32'h0);

      // LBU after reset
      issue(3'b100, 3'b111, 32'h0000_7000, 32'h0);
      step(); idle_in();
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_56F0;
      step(); mem_resp_valid = 1'b0;
      chk("lbu_done", {31'h0, done}, 32'h1);
      chk("lbu_rdata", rdata, 32'h0000_00F0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
